// File: rtl/board_test_pkg.sv
// board_test: encodings shared by the board-test switch debouncer and single-step clock controller
package board_test;
  localparam logic [2:0] DB_IDLE = 3'd0;
  localparam logic [2:0] DB_PRESS_WAIT = 3'd1;
  localparam logic [2:0] DB_PRESSED = 3'd2;
  localparam logic [2:0] DB_HOLD_REPEAT = 3'd3;
  localparam logic [2:0] DB_RELEASE_WAIT = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE = DB_IDLE,
    S_PRESS_WAIT = DB_PRESS_WAIT,
    S_PRESSED = DB_PRESSED,
    S_HOLD_REPEAT = DB_HOLD_REPEAT,
    S_RELEASE_WAIT = DB_RELEASE_WAIT
  } db_state_e;
  localparam logic [1:0] SS_IDLE = 2'd0;
  localparam logic [1:0] SS_GOING = 2'd1;
  localparam logic [1:0] SS_RESET = 2'd2;
  // one counter width fits every cycle-count parameter
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a configurable reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: debounces a board switch into a level, step strobes with auto-repeat, and release strobes
module sw_debounce import board_test::*; #(
  parameter int   DEBOUNCE_CYC = 500000,
  parameter int   HOLD_CYC = 25000000,
  parameter int   REPEAT_CYC = 5000000,
  parameter logic SW_ACTIVE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic sw_level,
  output logic step_pulse,
  output logic release_pulse,
  output logic repeating
);
  localparam int CW = cnt_w(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
  localparam logic [CW-1:0] D_T = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] H_T = CW'(HOLD_CYC == 0 ? 0 : HOLD_CYC - 1);
  localparam logic [CW-1:0] R_T = CW'(REPEAT_CYC == 0 ? 0 : REPEAT_CYC - 1);
  db_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n, hcnt, hcnt_n, rcnt, rcnt_n, h_sat, r_sat;
  logic sw_q, sw_s, from_rep, from_rep_n, level_n, step_n, rel_n;
  sync_2ff #(.RST_VAL(~SW_ACTIVE)) u_sync (.clk(clk), .rst_n(rst_n), .d(sw), .q(sw_q));
  assign sw_s = sw_q ~^ SW_ACTIVE;
  assign h_sat = hcnt + CW'(hcnt != H_T);
  assign r_sat = rcnt + CW'(rcnt != R_T);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      hcnt <= '0;
      rcnt <= '0;
      from_rep <= 1'b0;
      sw_level <= 1'b0;
      step_pulse <= 1'b0;
      release_pulse <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hcnt <= hcnt_n;
      rcnt <= rcnt_n;
      from_rep <= from_rep_n;
      sw_level <= level_n;
      step_pulse <= step_n;
      release_pulse <= rel_n;
      repeating <= state_n == S_HOLD_REPEAT;
    end
  // hold/repeat counts keep running through a release glitch so the repeat cadence survives it
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hcnt_n = hcnt;
    rcnt_n = rcnt;
    from_rep_n = from_rep;
    level_n = sw_level;
    step_n = 1'b0;
    rel_n = 1'b0;
    case (state)
      S_IDLE:
        if (sw_s) begin
          state_n = S_PRESS_WAIT;
          cnt_n = CW'(1);
        end
      S_PRESS_WAIT:
        if (!sw_s) begin
          state_n = S_IDLE;
          cnt_n = '0;
        end else if (cnt >= D_T) begin
          state_n = S_PRESSED;
          step_n = 1'b1;
          level_n = 1'b1;
          cnt_n = '0;
          hcnt_n = '0;
          rcnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      S_PRESSED: begin
        hcnt_n = h_sat;
        if (!sw_s) begin
          state_n = S_RELEASE_WAIT;
          cnt_n = CW'(1);
          from_rep_n = 1'b0;
        end else if (HOLD_CYC != 0 && hcnt == H_T) begin
          state_n = S_HOLD_REPEAT;
          step_n = 1'b1;
          rcnt_n = '0;
        end
      end
      S_HOLD_REPEAT:
        if (!sw_s) begin
          state_n = S_RELEASE_WAIT;
          cnt_n = CW'(1);
          from_rep_n = 1'b1;
          rcnt_n = r_sat;
        end else begin
          step_n = rcnt == R_T;
          rcnt_n = (rcnt == R_T) ? '0 : rcnt + 1'b1;
        end
      S_RELEASE_WAIT: begin
        hcnt_n = from_rep ? hcnt : h_sat;
        rcnt_n = from_rep ? r_sat : rcnt;
        if (sw_s) begin
          state_n = from_rep ? S_HOLD_REPEAT : S_PRESSED;
          cnt_n = '0;
        end else if (cnt >= D_T) begin
          state_n = S_IDLE;
          rel_n = 1'b1;
          level_n = 1'b0;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed and random switch activity checked against a timestamp-based reference model
module tb_sw_debounce;
  localparam int D = 4, H = 16, R = 8;
  logic clk = 1'b0, rst_n = 1'b0, sw = 1'b0;
  logic sw_level, step_pulse, release_pulse, repeating;
  int checks = 0, failures = 0, cyc = 0, rst_rel = 0, last = 0, nst = 0, b = 0, rep_first = -1;
  bit raw [0:8191];
  bit lvl = 1'b0;
  int stepq[$], relq[$];
  sw_debounce #(.DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R), .SW_ACTIVE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .sw_level(sw_level),
    .step_pulse(step_pulse), .release_pulse(release_pulse), .repeating(repeating));
  always #5 clk = ~clk;
  // synchronized, pressed-high view of the switch during cycle x (two cycles behind the pin, idle until resampled after reset)
  function automatic bit ssv(input int x);
    return (x >= rst_rel + 2 && x >= 2) ? raw[x-2] : 1'b0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask
  // level flips after D consecutive opposite samples; steps on press, then after H and every R stable-pressed cycles
  task automatic tick(input bit v, input bit r);
    bit e_step, e_rel, opp;
    @(posedge clk);
    cyc++;
    #1;
    e_step = 1'b0;
    e_rel = 1'b0;
    if (!rst_n) begin
      lvl = 1'b0;
      nst = 0;
    end else begin
      opp = 1'b1;
      for (int i = 1; i <= D; i++) if (ssv(cyc - i) == lvl) opp = 1'b0;
      if (opp) begin
        lvl = !lvl;
        e_step = lvl;
        e_rel = !lvl;
        nst = lvl ? 1 : 0;
        last = cyc;
      end else if (lvl && ssv(cyc - 1) && ssv(cyc - 2) && cyc - last >= (nst == 1 ? H : R)) begin
        e_step = 1'b1;
        last = cyc;
        nst++;
      end
    end
    chk("sw_level", sw_level, lvl);
    chk("step_pulse", step_pulse, e_step);
    chk("release_pulse", release_pulse, e_rel);
    chk("repeating", repeating, lvl && nst >= 2 && ssv(cyc - 1));
    chk("pulse_overlap", step_pulse & release_pulse, 0);
    if (step_pulse === 1'b1) stepq.push_back(cyc);
    if (release_pulse === 1'b1) relq.push_back(cyc);
    if (repeating === 1'b1 && rep_first < 0) rep_first = cyc;
    sw = v;
    raw[cyc] = v;
    if (r && !rst_n) rst_rel = cyc;
    rst_n = r;
  endtask
  task automatic run(input bit v, input int n, input bit r);
    for (int i = 0; i < n; i++) tick(v, r);
  endtask
  task automatic begin_case;
    stepq.delete();
    relq.delete();
    rep_first = -1;
    b = cyc + 1;
  endtask
  initial begin
    run(1'b0, 3, 1'b0);
    run(1'b0, 8, 1'b1);
    begin_case;
    run(1'b1, 10, 1'b1);
    run(1'b0, 14, 1'b1);
    chk("press_step_count", stepq.size(), 1);
    chk("press_step_cycle", stepq.size() > 0 ? stepq[0] : -1, b + 6);
    chk("release_count", relq.size(), 1);
    chk("release_cycle", relq.size() > 0 ? relq[0] : -1, b + 16);
    begin_case;
    run(1'b1, 1, 1'b1);
    run(1'b0, 1, 1'b1);
    run(1'b1, 1, 1'b1);
    run(1'b0, 12, 1'b1);
    chk("bounce_steps", stepq.size(), 0);
    chk("bounce_releases", relq.size(), 0);
    begin_case;
    run(1'b1, 40, 1'b1);
    run(1'b0, 14, 1'b1);
    chk("hold_step_count", stepq.size(), 4);
    chk("hold_step0", stepq.size() > 0 ? stepq[0] : -1, b + 6);
    chk("hold_step1", stepq.size() > 1 ? stepq[1] : -1, b + 22);
    chk("hold_step2", stepq.size() > 2 ? stepq[2] : -1, b + 30);
    chk("hold_step3", stepq.size() > 3 ? stepq[3] : -1, b + 38);
    chk("repeat_start", rep_first, b + 22);
    begin_case;
    run(1'b1, 8, 1'b1);
    run(1'b0, 2, 1'b1);
    run(1'b1, 17, 1'b1);
    run(1'b0, 14, 1'b1);
    chk("glitch_step_count", stepq.size(), 2);
    chk("glitch_repeat_cycle", stepq.size() > 1 ? stepq[1] : -1, b + 22);
    chk("glitch_release_count", relq.size(), 1);
    begin_case;
    run(1'b1, 4, 1'b1);
    run(1'b1, 3, 1'b0);
    run(1'b1, 10, 1'b1);
    run(1'b0, 14, 1'b1);
    chk("rst_press_step_count", stepq.size(), 1);
    chk("rst_press_step_cycle", stepq.size() > 0 ? stepq[0] : -1, b + 13);
    for (int k = 0; k < 60; k++) begin
      bit v;
      int n;
      v = k[0];
      n = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 45);
      if ($urandom_range(0, 11) == 0) run(v, 2, 1'b0);
      run(v, n, 1'b1);
    end
    run(1'b0, 20, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
